// File: rtl/hjreg_pkg.sv
// Shared definitions for the AXI4-Lite to regreq/regack register bridge.
//   RESP_OKAY / RESP_SLVERR : AXI response encodings
//   state_e                 : bridge FSM states
//   DEAD_DATA               : read data returned when the register slave never answers
package hjreg_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] DEAD_DATA   = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    BRESP = 3'd3,
    RRESP = 3'd4
  } state_e;

endpackage

// File: rtl/axi_regbridge.sv
// AXI4-Lite slave that serialises host accesses onto a single-outstanding
// regreq/regack register bus (register master for hjdebug-style slaves).
//
// Build option: REGBRIDGE_TIMEOUT_EN -- when defined, WAIT gives up after
// TIMEOUT cycles without regack and answers SLVERR (reads return DEAD_DATA).
// When undefined WAIT holds until regack and no counter exists.
//
// Ports
//   clk, rstn                      clock, async active-low reset
//   s_aw*/s_w*/s_b*                AXI-Lite write address/data/response channels
//   s_ar*/s_r*                     AXI-Lite read address/response channels
//   regreq                         one-cycle request pulse
//   regwr, regaddr, regwdata       request attributes, held from regreq until regack
//   regack, regerr, regrdata       completion pulse, error flag, read data
module axi_regbridge
  import hjreg_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [31:0]       s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              regreq,
  output logic              regwr,
  output logic [ADDR_W-1:0] regaddr,
  output logic [31:0]       regwdata,
  input  logic              regack,
  input  logic              regerr,
  input  logic [31:0]       regrdata
);

  state_e              state_q, state_d;
  logic                aw_held_q, w_held_q, ar_held_q;
  logic                aw_held_d, w_held_d, ar_held_d;
  logic [ADDR_W-1:0]   aw_addr_q, ar_addr_q;
  logic [31:0]         w_data_q;
  logic [3:0]          w_strb_q;
  logic                rr_rd_q;     // 0: write wins a tie, 1: read wins
  logic                aw_hs, w_hs, ar_hs;
  logic                wr_elig, rd_elig, strb_ok;
  logic                grant_wr, grant_rd, leave_wait, wr_done, rd_done;
  logic                timeout_hit;
  logic [1:0]          resp_d;

  // Host address bits above the register window are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{s_awaddr[31:ADDR_W], s_araddr[31:ADDR_W]};

  assign aw_hs   = s_awvalid & s_awready;
  assign w_hs    = s_wvalid  & s_wready;
  assign ar_hs   = s_arvalid & s_arready;
  assign wr_elig = aw_held_q & w_held_q;
  assign rd_elig = ar_held_q;
  assign strb_ok = (w_strb_q == 4'hF);
  // A timeout without regack is reported as a slave error.
  assign resp_d  = (regack && !regerr) ? RESP_OKAY : RESP_SLVERR;

`ifdef REGBRIDGE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  // Counts completed WAIT cycles; WAIT lasts at most TIMEOUT cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  assign timeout_hit = (state_q == WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state, arbitration and transaction-completion decode.
  always_comb begin
    state_d    = state_q;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    leave_wait = 1'b0;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_elig && (!rd_elig || !rr_rd_q)) begin
          grant_wr = 1'b1;
          state_d  = strb_ok ? ISSUE : BRESP;
        end else if (rd_elig) begin
          grant_rd = 1'b1;
          state_d  = ISSUE;
        end
      end
      // An ack coinciding with the request cycle is not looked at here.
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (regack || timeout_hit) begin
          leave_wait = 1'b1;
          state_d    = regwr ? BRESP : RRESP;
        end
      end
      BRESP: begin
        if (s_bready) begin
          wr_done = 1'b1;
          state_d = IDLE;
        end
      end
      RRESP: begin
        if (s_rready) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding registers stay full until their own response handshake completes.
  assign aw_held_d = (aw_held_q | aw_hs) & ~wr_done;
  assign w_held_d  = (w_held_q  | w_hs)  & ~wr_done;
  assign ar_held_d = (ar_held_q | ar_hs) & ~rd_done;

  // State, holding registers and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      ar_held_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      rr_rd_q   <= 1'b0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_arready <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      s_rvalid  <= 1'b0;
      s_rresp   <= RESP_OKAY;
      s_rdata   <= '0;
      regreq    <= 1'b0;
      regwr     <= 1'b0;
      regaddr   <= '0;
      regwdata  <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      ar_held_q <= ar_held_d;
      if (aw_hs) aw_addr_q <= s_awaddr[ADDR_W-1:0];
      if (ar_hs) ar_addr_q <= s_araddr[ADDR_W-1:0];
      if (w_hs) begin
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end

      s_awready <= (state_d == IDLE) && !aw_held_d;
      s_wready  <= (state_d == IDLE) && !w_held_d;
      s_arready <= (state_d == IDLE) && !ar_held_d;
      s_bvalid  <= (state_d == BRESP);
      s_rvalid  <= (state_d == RRESP);
      regreq    <= (state_d == ISSUE);

      if (grant_wr || grant_rd) rr_rd_q <= grant_wr;

      if (grant_wr && strb_ok) begin
        regwr    <= 1'b1;
        regaddr  <= aw_addr_q;
        regwdata <= w_data_q;
      end
      if (grant_rd) begin
        regwr   <= 1'b0;
        regaddr <= ar_addr_q;
      end

      // Partial-strobe writes are refused without touching the register bus.
      if (grant_wr && !strb_ok) s_bresp <= RESP_SLVERR;

      if (leave_wait) begin
        if (regwr) begin
          s_bresp <= resp_d;
        end else begin
          s_rresp <= resp_d;
          s_rdata <= regack ? regrdata : DEAD_DATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_regbridge.sv
// Directed self-checking bench for axi_regbridge with a behavioural register slave.
module tb_axi_regbridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        regreq, regwr;
  logic [11:0] regaddr;
  logic [31:0] regwdata;
  logic        regack, regerr;
  logic [31:0] regrdata;

  int checks   = 0;
  int failures = 0;

  // Slave model controls and observations.
  logic        slv_ack_en = 1'b1;
  int          slv_dly    = 1;
  logic        slv_err    = 1'b0;
  logic [31:0] slv_rdata  = '0;
  logic        slv_busy   = 1'b0;
  int          req_cnt    = 0;
  int          unstable   = 0;
  int          b_beats    = 0;
  logic [7:0]  grant_seq  = '0;
  logic        lst_wr;
  logic [11:0] lst_addr;
  logic [31:0] lst_wdata;

  always #5 clk = ~clk;

  axi_regbridge #(.ADDR_W(12), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .regreq(regreq), .regwr(regwr), .regaddr(regaddr), .regwdata(regwdata),
    .regack(regack), .regerr(regerr), .regrdata(regrdata)
  );

  always @(posedge clk) begin
    if (s_bvalid && s_bready) b_beats++;
  end

  // Register slave: sees regreq, acks slv_dly cycles later, checks attribute stability.
  initial begin
    regack = 1'b0; regerr = 1'b0; regrdata = '0;
    forever begin
      @(negedge clk);
      if (regreq === 1'b1) begin
        req_cnt++;
        lst_wr    = regwr;
        lst_addr  = regaddr;
        lst_wdata = regwdata;
        grant_seq = {grant_seq[6:0], regwr};
        if (slv_ack_en) begin
          slv_busy = 1'b1;
          for (int i = 0; i < slv_dly; i++) begin
            @(posedge clk); #1;
            if (regwr !== lst_wr || regaddr !== lst_addr || regwdata !== lst_wdata) unstable++;
          end
          regerr = slv_err; regrdata = slv_rdata; regack = 1'b1;
          @(posedge clk); #1;
          regack = 1'b0; regerr = 1'b0; regrdata = '0;
          slv_busy = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic aw_hs(input logic [31:0] a);
    int n = 0;
    s_awaddr = a; s_awvalid = 1'b1;
    while (s_awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("aw_handshake_bound", 32'(n < 50), 32'd1);
    @(negedge clk); s_awvalid = 1'b0;
  endtask

  task automatic w_hs(input logic [31:0] d, input logic [3:0] st);
    int n = 0;
    s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
    while (s_wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("w_handshake_bound", 32'(n < 50), 32'd1);
    @(negedge clk); s_wvalid = 1'b0;
  endtask

  task automatic ar_hs(input logic [31:0] a);
    int n = 0;
    s_araddr = a; s_arvalid = 1'b1;
    while (s_arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("ar_handshake_bound", 32'(n < 50), 32'd1);
    @(negedge clk); s_arvalid = 1'b0;
  endtask

  task automatic wait_b(input string tag, input logic [1:0] exp_resp);
    int n = 0;
    while (s_bvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_bvalid_bound"}, 32'(n < 100), 32'd1);
    chk({tag, "_bresp"}, 32'(s_bresp), 32'(exp_resp));
    s_bready = 1'b1; @(negedge clk); s_bready = 1'b0;
    chk({tag, "_bvalid_drop"}, 32'(s_bvalid), 32'd0);
  endtask

  // Returns cycles from the call point (negedge after AR handshake) to s_rvalid.
  task automatic wait_r(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                        output int lat);
    int n = 0;
    while (s_rvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    lat = n;
    chk({tag, "_rvalid_bound"}, 32'(n < 100), 32'd1);
    chk({tag, "_rdata"}, s_rdata, exp_data);
    chk({tag, "_rresp"}, 32'(s_rresp), 32'(exp_resp));
    s_rready = 1'b1; @(negedge clk); s_rready = 1'b0;
    chk({tag, "_rvalid_drop"}, 32'(s_rvalid), 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat, rq0, b0, n;
    rstn = 1'b0;
    s_awvalid = 1'b0; s_awaddr = '0; s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    s_bready = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_rready = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_ready", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
    chk("rst_valid", {29'd0, s_bvalid, s_rvalid, regreq}, 32'd0);
    chk("rst_regbus", {19'd0, regwr, regaddr}, 32'd0);
    chk("rst_resp_data", s_rdata | regwdata | {28'd0, s_bresp, s_rresp}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", {29'd0, s_awready, s_wready, s_arready}, 32'd7);

    // 1: AW first, W three cycles later, 1-cycle ack.
    rq0 = req_cnt; b0 = b_beats; slv_dly = 1;
    aw_hs(32'hABCD_0010);
    repeat (2) @(negedge clk);
    w_hs(32'hCAFE_F00D, 4'hF);
    wait_b("t1", 2'b00);
    repeat (2) @(negedge clk);
    chk("t1_req_count", 32'(req_cnt - rq0), 32'd1);
    chk("t1_regwr", 32'(lst_wr), 32'd1);
    chk("t1_regaddr", 32'(lst_addr), 32'h010);
    chk("t1_regwdata", lst_wdata, 32'hCAFE_F00D);
    chk("t1_b_beats", 32'(b_beats - b0), 32'd1);

    // 2: read 0x004 with a 5-cycle slave; data held while rready low.
    slv_dly = 5; slv_rdata = 32'h0000_0400;
    ar_hs(32'h0000_0004);
    n = 0;
    while (s_rvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("t2_rdata_hold", s_rdata, 32'h0000_0400);
    wait_r("t2", 32'h0000_0400, 2'b00, lat);
    chk("t2_regwr", 32'(lst_wr), 32'd0);
    chk("t2_regaddr", 32'(lst_addr), 32'h004);

    // 2b: minimum read latency with a 1-cycle slave.
    slv_dly = 1; slv_rdata = 32'h1234_5678;
    ar_hs(32'h0000_0008);
    wait_r("t2b", 32'h1234_5678, 2'b00, lat);
    chk("t2b_latency", 32'(lat), 32'd3);

    // 3: write and read eligible together, twice, from the reset pointer.
    do_reset();
    rq0 = req_cnt; slv_rdata = 32'h0000_3003;
    for (int r = 0; r < 2; r++) begin
      s_awaddr = 32'h020; s_wdata = 32'h5555_0000 + 32'(r); s_wstrb = 4'hF; s_araddr = 32'h030;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
      n = 0;
      while (!(s_awready && s_wready && s_arready) && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      wait_b("t3_w", 2'b00);
      wait_r("t3_r", 32'h0000_3003, 2'b00, lat);
    end
    chk("t3_req_count", 32'(req_cnt - rq0), 32'd4);
    chk("t3_grant_order", 32'(grant_seq[3:0]), 32'b1010);

    // 4: partial strobe refused without a request; slave error on a read.
    rq0 = req_cnt;
    aw_hs(32'h040);
    w_hs(32'h0BAD_0BAD, 4'h3);
    wait_b("t4_w", 2'b10);
    repeat (3) @(negedge clk);
    chk("t4_no_regreq", 32'(req_cnt - rq0), 32'd0);
    slv_err = 1'b1; slv_rdata = 32'h0000_0055;
    ar_hs(32'h044);
    wait_r("t4_r", 32'h0000_0055, 2'b10, lat);
    slv_err = 1'b0;

`ifdef REGBRIDGE_TIMEOUT_EN
    // 5: slave answers only after the 16-cycle WAIT window (AR reg + ISSUE + 16 WAIT).
    slv_dly = 25;
    ar_hs(32'h050);
    wait_r("t5", 32'hDEAD_BEEF, 2'b10, lat);
    chk("t5_latency", 32'(lat), 32'd18);
    n = 0;
    while (slv_busy && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("t5_late_ack_ignored", {30'd0, s_bvalid, s_rvalid}, 32'd0);
    chk("t5_idle_after", 32'(s_arready), 32'd1);
    slv_dly = 1;
`endif

    // 6: asynchronous reset while waiting on a silent slave.
    slv_ack_en = 1'b0;
    ar_hs(32'h060);
    repeat (3) @(negedge clk);
    chk("t6_stuck_in_wait", 32'(s_arready), 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_clear", {28'd0, s_rvalid, s_bvalid, regreq, s_arready}, 32'd0);
    @(negedge clk);
    rstn = 1'b1; slv_ack_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_resp_dropped", {30'd0, s_rvalid, s_bvalid}, 32'd0);
    chk("t6_idle_ready", 32'(s_arready), 32'd1);
    slv_rdata = 32'h6666_0001;
    ar_hs(32'h064);
    wait_r("t6_after", 32'h6666_0001, 2'b00, lat);

    chk("reg_attr_stable", 32'(unstable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
